// File: rtl/fwd_hazard_unit.sv
// Data-hazard unit: tracks in-flight writers per back-end stage, selects EX forwards, raises load-use stall.
// Optional HAZARD_STATS_EN adds stall_cnt/fwd_cnt event counters.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  localparam int unsigned SEL_W     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_SRC*5-1:0]     id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [4:0]               id_rd,
  input  logic                     id_regwr,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     ex_load_pending
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              fwd_cnt
`endif
);

  logic [DEPTH-1:0]     t_valid;
  logic [DEPTH-1:0]     t_regwr;
  logic [DEPTH-1:0]     t_load;
  logic [4:0]           t_rd [DEPTH];
  // Source fields only matter while the instruction sits in EX, so only entry 0 keeps them.
  logic [NUM_SRC*5-1:0] ex_rs;
  logic [NUM_SRC-1:0]   ex_rs_used;
  logic                 load_en;
  logic                 load_hit;

  assign load_en = id_valid & ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_valid    <= '0;
      t_regwr    <= '0;
      t_load     <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) t_rd[k] <= '0;
      ex_rs      <= '0;
      ex_rs_used <= '0;
    end else begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        t_valid[k] <= t_valid[k-1];
        t_regwr[k] <= t_regwr[k-1];
        t_load[k]  <= t_load[k-1];
        t_rd[k]    <= t_rd[k-1];
      end
      t_valid[0] <= load_en;
      t_regwr[0] <= load_en & id_regwr;
      t_load[0]  <= load_en & id_is_load;
      t_rd[0]    <= load_en ? id_rd : '0;
      ex_rs      <= load_en ? id_rs : '0;
      ex_rs_used <= load_en ? id_rs_used : '0;
    end
  end

  function automatic logic writes(input int unsigned k, input logic [4:0] r);
    return t_valid[k] && t_regwr[k] && (t_rd[k] != 5'd0) && (t_rd[k] == r);
  endfunction

  // Scan oldest to youngest so the youngest eligible writer overwrites last.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
        if (t_valid[0] && ex_rs_used[i] && writes(k, ex_rs[i*5 +: 5]) &&
            !(t_load[k] && (k < LOAD_READY)))
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
      end
    end
  end

  always_comb begin
    load_hit = 1'b0;
    for (int unsigned k = 0; (k + 1 < LOAD_READY) && (k < DEPTH); k++) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (t_load[k] && id_rs_used[i] && writes(k, id_rs[i*5 +: 5]))
          load_hit = 1'b1;
      end
    end
  end

  assign stall           = id_valid & ~flush & load_hit;
  assign ex_load_pending = t_valid[0] & t_load[0];

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall)    stall_cnt <= stall_cnt + 32'd1;
      if (|fwd_sel) fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised data-hazard unit for the pipelined RISC-V core. It replaces the single-stage combinational forward check.
- Tracks in-flight writers in an internal shift tracker, one entry per back-end stage (EX, MEM, WB, ...).
- Produces per-operand forward selects for the instruction in EX, with youngest-writer priority.
- Generates the load-use stall for the instruction in decode.
- Sits between the decode stage, the EX operand muxes and the IF/ID enable logic.

Parameters:
NUM_SRC, 2, number of source operands per instruction (rs1, rs2, optionally rs3)
DEPTH, 3, tracker entries; entry 0 = EX, entry 1 = MEM, entry 2 = WB, ... (min 2)
LOAD_READY, 2, first tracker index at which load data is forwardable
SEL_W, $clog2(DEPTH), width of one forward select (derived, not overridden)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a valid instruction
id_rs  in  NUM_SRC*5  decode source regs; operand i at [i*5 +: 5]
id_rs_used  in  NUM_SRC  operand i actually read by the decode instruction
id_rd  in  5  decode destination reg
id_regwr  in  1  decode instruction writes rd
id_is_load  in  1  decode instruction is a load
flush  in  1  squash decode instruction (branch/jump taken in EX)
stall  out  1  hold PC and IF/ID; bubble into EX
fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = regfile value, k = forward from tracker entry k
ex_load_pending  out  1  tracker entry 0 holds a valid load

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high (rst). Every register updates on the clk rising edge only.
- Tracker entry fields: valid, regwr, is_load, rd[4:0], rs[NUM_SRC], rs_used[NUM_SRC].
- Reset (rst=1 at the edge): all entries valid=0. On the following cycle stall=0, fwd_sel=0 and ex_load_pending=0, whatever the id_* inputs. Reset mid-stall drops the stall in the next cycle.
- Shift every cycle, unconditionally (the back end never stalls): entry[k+1] <= entry[k] for k=0..DEPTH-2. Entry DEPTH-1 retires.
- Entry 0 load:
  - If rst, or flush, or stall, or !id_valid: entry[0] <= bubble (valid=0).
  - Otherwise entry[0] <= decode fields.
- Writer match(k, r), true when all hold:
  - entry[k].valid and entry[k].regwr
  - entry[k].rd != 0 and entry[k].rd == r
  - x0 never matches.
- fwd_sel[i] (combinational from the tracker):
  - Equals the smallest k in 1..DEPTH-1 with match(k, entry[0].rs[i]) and entry[0].rs_used[i]. Youngest writer wins.
  - Equals 0 if there is no match or entry[0] is invalid.
  - An entry with is_load=1 and k < LOAD_READY is never selected.
- stall (combinational) is 1 when all hold:
  - id_valid and !flush
  - some k, with 0 <= k and k+1 < LOAD_READY, has entry[k].is_load and match(k, id_rs[i]) for some i with id_rs_used[i].
  - Default parameters: only a load in EX matching a used decode source causes a stall. That is exactly 1 stall cycle, because the load reaches entry 1 and the next check fails.
- Flush and stall in the same cycle: flush wins, stall=0, and a bubble enters.
- Store / branch (regwr=0) entries never forward.
- ex_load_pending = entry[0].valid & entry[0].is_load.
- No X on outputs after reset, including with id_* driven X while id_valid=0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and fwd_cnt[31:0].
  - stall_cnt increments on every cycle with stall=1.
  - fwd_cnt increments once per cycle in which any fwd_sel[i] != 0.
  - Both clear on rst and wrap at 2^32-1 -> 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Back-to-back ALU (defaults): add x5 issues, then sub uses x5 as rs1 the next cycle -> while sub is in EX, fwd_sel[0]=1 and fwd_sel[1]=0; stall=0 throughout.
2. Youngest priority: three consecutive writes to x7, then a use of x7 -> fwd_sel[0]=1 (the MEM copy, not WB).
3. Load-use: lw x3 in EX, decode has add with rs2=x3 used -> stall=1 for exactly 1 cycle. Then add enters EX with fwd_sel[1]=2 and no further stall. Repeat with id_rs_used[1]=0 -> stall=0.
4. x0 and non-writers: writer rd=x0, or a store with rs field x9 followed by a use of x9 -> fwd_sel=0.
5. Flush during load-use: lw x3 in EX, flush=1 with a dependent instruction in decode -> stall=0. Next cycle entry 0 is a bubble, fwd_sel=0.
6. Reset mid-stall: assert rst while stall=1 -> next cycle stall=0, fwd_sel=0, ex_load_pending=0. With HAZARD_STATS_EN: stall_cnt=0 after reset, and it counts 1 per stall cycle in scenario 3.
